// File: rtl/vga_timing_pkg.sv
// ------------------------------------------------------------------
// vga_timing_pkg : timing-mode constants and helpers for vga_timing_gen
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        int unsigned v_active;
        int unsigned v_fp;
    } vga_mode_t;

    typedef enum logic [0:0] {
        MODE_SVGA_800X600 = 1'b0,
        MODE_VGA_640X480  = 1'b1
    } vga_mode_e;

    // Control bundle carried through the latency-matching delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic fs;
        logic ls;
    } vga_ctl_t;

    localparam vga_mode_t MODE_800X600_60 = '{
        h_sync: 128, h_bp: 88, h_active: 800, h_fp: 40,
        v_sync: 4,   v_bp: 23, v_active: 600, v_fp: 1
    };

    localparam vga_mode_t MODE_640X480_60 = '{
        h_sync: 96, h_bp: 48, h_active: 640, h_fp: 16,
        v_sync: 2,  v_bp: 33, v_active: 480, v_fp: 10
    };

    function automatic int unsigned span_total(
        input int unsigned sync_w,
        input int unsigned bp_w,
        input int unsigned active_w,
        input int unsigned fp_w
    );
        return sync_w + bp_w + active_w + fp_w;
    endfunction

    function automatic vga_mode_t mode_lookup(input vga_mode_e sel);
        return (sel == MODE_VGA_640X480) ? MODE_640X480_60 : MODE_800X600_60;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ------------------------------------------------------------------
// vga_timing_gen_if : pixel-request / VGA-output bundle of vga_timing_gen
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if #(
    parameter int unsigned CW    = 11,
    parameter int unsigned RGB_W = 8
);
    logic [RGB_W-1:0] vga_data;
    logic [CW-1:0]    vga_xide;
    logic [CW-1:0]    vga_yide;
    logic             vga_req;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_de;
    logic [RGB_W-1:0] vga_rgb;
    logic             frame_start;
    logic             line_start;

    modport master (
        input  vga_data,
        output vga_xide, vga_yide, vga_req,
        output vga_hs, vga_vs, vga_de, vga_rgb,
        output frame_start, line_start
    );

    modport slave (
        output vga_data,
        input  vga_xide, vga_yide, vga_req,
        input  vga_hs, vga_vs, vga_de, vga_rgb,
        input  frame_start, line_start
    );
endinterface

`default_nettype wire

// File: rtl/vga_pipe_delay.sv
// ------------------------------------------------------------------
// vga_pipe_delay : WIDTH x DEPTH shift register with flush; DEPTH=0 is a wire
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_pipe_delay #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             flush_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused_ctl;
        assign w_unused_ctl = ^{clk_i, rst_ni, flush_i};
        assign q_o          = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Flush empties every stage at once; nothing in flight survives
        always_ff @(posedge clk_i) begin
            if (!rst_ni || flush_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ------------------------------------------------------------------
// vga_timing_gen : parametrised VGA timing with pixel-fetch latency alignment
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = MODE_800X600_60.h_sync,
    parameter int unsigned H_BP     = MODE_800X600_60.h_bp,
    parameter int unsigned H_ACTIVE = MODE_800X600_60.h_active,
    parameter int unsigned H_FP     = MODE_800X600_60.h_fp,
    parameter int unsigned V_SYNC   = MODE_800X600_60.v_sync,
    parameter int unsigned V_BP     = MODE_800X600_60.v_bp,
    parameter int unsigned V_ACTIVE = MODE_800X600_60.v_active,
    parameter int unsigned V_FP     = MODE_800X600_60.v_fp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned RGB_W    = 8,
    parameter int unsigned DATA_LAT = 1,
    parameter int unsigned CW       = 11
) (
    input wire logic         clk_40mhz,
    input wire logic         rst_n,
    input wire logic         en,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = span_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL = span_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT0     = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT1     = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT0     = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT1     = CW'(V_SYNC + V_BP + V_ACTIVE);

    localparam vga_ctl_t CTL_IDLE = '{
        hs: ~HS_POL, vs: ~VS_POL, act: 1'b0, fs: 1'b0, ls: 1'b0
    };

    logic [CW-1:0]    hcnt_q, hcnt_d;
    logic [CW-1:0]    vcnt_q, vcnt_d;
    logic             hs_q, vs_q, de_q, fs_q, ls_q;
    logic [RGB_W-1:0] rgb_q;

    logic             w_h_win, w_v_win, w_act;
    vga_ctl_t         w_ctl0, w_ctl_dly;

    // Disabled counters park at (0,0) so re-enabling always starts a fresh frame
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!en) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
        end else begin
            hcnt_d = hcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_40mhz) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign w_h_win = (hcnt_q >= H_ACT0) && (hcnt_q < H_ACT1);
    assign w_v_win = (vcnt_q >= V_ACT0) && (vcnt_q < V_ACT1);
    assign w_act   = en && w_h_win && w_v_win;

    assign bus.vga_req  = w_act;
    assign bus.vga_xide = w_act ? (hcnt_q - H_ACT0) : '0;
    assign bus.vga_yide = w_act ? (vcnt_q - V_ACT0) : '0;

    // Stage 0 is forced idle while disabled so a zero-depth delay line also goes quiet
    always_comb begin
        w_ctl0 = CTL_IDLE;
        if (en) begin
            w_ctl0.hs  = (hcnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
            w_ctl0.vs  = (vcnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
            w_ctl0.act = w_act;
            w_ctl0.fs  = (hcnt_q == '0) && (vcnt_q == '0);
            w_ctl0.ls  = (hcnt_q == '0);
        end
    end

    vga_pipe_delay #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (DATA_LAT),
        .RST_VAL (CTL_IDLE)
    ) u_ctl_dly (
        .clk_i   (clk_40mhz),
        .rst_ni  (rst_n),
        .flush_i (!en),
        .d_i     (w_ctl0),
        .q_o     (w_ctl_dly)
    );

    always_ff @(posedge clk_40mhz) begin
        if (!rst_n) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= w_ctl_dly.hs;
            vs_q  <= w_ctl_dly.vs;
            de_q  <= w_ctl_dly.act;
            fs_q  <= w_ctl_dly.fs;
            ls_q  <= w_ctl_dly.ls;
            rgb_q <= w_ctl_dly.act ? bus.vga_data : '0;
        end
    end

    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_de      = de_q;
    assign bus.vga_rgb     = rgb_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ------------------------------------------------------------------
// tb_vga_timing_gen : three modes checked cycle-by-cycle against a raster model
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

    localparam int NDUT = 3;

    typedef struct {
        int hs; int hb; int ha; int hf;
        int vs; int vb; int va; int vf;
        bit hp; bit vp; int lat;
    } mode_t;

    typedef struct {
        bit ok; bit hs; bit vs; bit de; bit fs; bit ls;
        int x;  int y;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] rst_n_v;
    logic [NDUT-1:0] en_v;

    vga_timing_gen_if #(.CW(11), .RGB_W(8)) if_a ();
    vga_timing_gen_if #(.CW(11), .RGB_W(8)) if_b ();
    vga_timing_gen_if #(.CW(11), .RGB_W(8)) if_c ();

    vga_timing_gen u_dut_a (
        .clk_40mhz (clk),
        .rst_n     (rst_n_v[0]),
        .en        (en_v[0]),
        .bus       (if_a)
    );

    vga_timing_gen #(
        .H_SYNC(8), .H_BP(6), .H_ACTIVE(40), .H_FP(4),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(20), .V_FP(2),
        .HS_POL(1'b0), .VS_POL(1'b1), .DATA_LAT(2)
    ) u_dut_b (
        .clk_40mhz (clk),
        .rst_n     (rst_n_v[1]),
        .en        (en_v[1]),
        .bus       (if_b)
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(0)
    ) u_dut_c (
        .clk_40mhz (clk),
        .rst_n     (rst_n_v[2]),
        .en        (en_v[2]),
        .bus       (if_c)
    );

    mode_t      md      [NDUT];
    int         pcur    [NDUT];
    ent_t       hist    [NDUT][5];
    ent_t       exp_o   [NDUT];
    logic [7:0] exp_rgb [NDUT];
    logic [7:0] dat     [NDUT];
    logic [7:0] rq_b    [3];

    int n_cmp = 0;
    int n_bad = 0;
    int edges_seen = 0;
    int a_armed = 0, a_hs_cnt = 0, a_de_cnt = 0;
    int b_armed = 0, b_cnt = 0;

    function automatic int htot(input mode_t m);
        return m.hs + m.hb + m.ha + m.hf;
    endfunction

    function automatic int vtot(input mode_t m);
        return m.vs + m.vb + m.va + m.vf;
    endfunction

    function automatic ent_t idle_ent(input mode_t m);
        ent_t e;
        e.ok = 1'b0; e.hs = ~m.hp; e.vs = ~m.vp;
        e.de = 1'b0; e.fs = 1'b0; e.ls = 1'b0; e.x = 0; e.y = 0;
        return e;
    endfunction

    // Raster position p (clocks since frame start) -> what the screen should show
    function automatic ent_t pos_ent(input mode_t m, input int p);
        ent_t e;
        int h, v;
        h = p % htot(m);
        v = (p / htot(m)) % vtot(m);
        e.ok = 1'b1;
        e.hs = (h < m.hs) ? m.hp : ~m.hp;
        e.vs = (v < m.vs) ? m.vp : ~m.vp;
        e.de = (h >= m.hs + m.hb) && (h < m.hs + m.hb + m.ha) &&
               (v >= m.vs + m.vb) && (v < m.vs + m.vb + m.va);
        e.x  = e.de ? h - (m.hs + m.hb) : 0;
        e.y  = e.de ? v - (m.vs + m.vb) : 0;
        e.fs = (h == 0) && (v == 0);
        e.ls = (h == 0);
        return e;
    endfunction

    function automatic logic [7:0] pick_data();
        int unsigned r;
        r = $urandom;
        if (r[1:0] == 2'd0) return 8'hFF;
        return r[15:8];
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, expv);
        end
    endtask

    // A pixel reaches the pins lat+1 edges after issue, unless reset/disable intervened
    task automatic model_edge(input int d);
        bit   run;
        ent_t e;
        run = rst_n_v[d] && en_v[d];
        for (int i = 4; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = run ? pos_ent(md[d], pcur[d]) : idle_ent(md[d]);
        e = hist[d][md[d].lat];
        for (int i = 1; i <= md[d].lat; i++) begin
            if (!hist[d][i].ok) e = idle_ent(md[d]);
        end
        if (!rst_n_v[d]) e = idle_ent(md[d]);
        exp_o[d] = e;
        if (!e.de)       exp_rgb[d] = 8'h00;
        else if (d == 1) exp_rgb[d] = {e.x[3:0], e.y[3:0]};
        else             exp_rgb[d] = dat[d];
        pcur[d] = run ? (pcur[d] + 1) % (htot(md[d]) * vtot(md[d])) : 0;
    endtask

    task automatic check_req(input int d, input logic req, input logic [10:0] x,
                             input logic [10:0] y);
        ent_t e;
        e = en_v[d] ? pos_ent(md[d], pcur[d]) : idle_ent(md[d]);
        chk("req",  d, req, e.de);
        chk("xide", d, x,   e.x);
        chk("yide", d, y,   e.y);
    endtask

    task automatic check_out(input int d, input logic hs, input logic vs, input logic de,
                             input logic fs, input logic ls, input logic [7:0] rgb);
        chk("hs",  d, hs,  exp_o[d].hs);
        chk("vs",  d, vs,  exp_o[d].vs);
        chk("de",  d, de,  exp_o[d].de);
        chk("fs",  d, fs,  exp_o[d].fs);
        chk("ls",  d, ls,  exp_o[d].ls);
        chk("rgb", d, rgb, exp_rgb[d]);
    endtask

    // One clock: drive data, check requests, clock, check outputs and line/frame stats
    task automatic cycle();
        dat[0] = pick_data();
        dat[2] = pick_data();
        if_a.vga_data = dat[0];
        if_c.vga_data = dat[2];
        #1;
        if (edges_seen > 0) begin
            check_req(0, if_a.vga_req, if_a.vga_xide, if_a.vga_yide);
            check_req(1, if_b.vga_req, if_b.vga_xide, if_b.vga_yide);
            check_req(2, if_c.vga_req, if_c.vga_xide, if_c.vga_yide);
        end
        rq_b[2] = rq_b[1];
        rq_b[1] = rq_b[0];
        rq_b[0] = {if_b.vga_xide[3:0], if_b.vga_yide[3:0]};
        dat[1]  = rq_b[2];
        if_b.vga_data = dat[1];
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_edge(d);
        edges_seen++;
        @(negedge clk);
        check_out(0, if_a.vga_hs, if_a.vga_vs, if_a.vga_de, if_a.frame_start,
                  if_a.line_start, if_a.vga_rgb);
        check_out(1, if_b.vga_hs, if_b.vga_vs, if_b.vga_de, if_b.frame_start,
                  if_b.line_start, if_b.vga_rgb);
        check_out(2, if_c.vga_hs, if_c.vga_vs, if_c.vga_de, if_c.frame_start,
                  if_c.line_start, if_c.vga_rgb);

        if (!en_v[0] || !rst_n_v[0]) a_armed = 0;
        if (if_a.line_start === 1'b1) begin
            if (a_armed != 0) begin
                chk("a_hs_low_per_line", 0, a_hs_cnt, 128);
                if (a_de_cnt != 0) chk("a_de_per_line", 0, a_de_cnt, 800);
            end
            a_armed  = 1;
            a_hs_cnt = (if_a.vga_hs === 1'b0) ? 1 : 0;
            a_de_cnt = (if_a.vga_de === 1'b1) ? 1 : 0;
        end else begin
            a_hs_cnt += (if_a.vga_hs === 1'b0) ? 1 : 0;
            a_de_cnt += (if_a.vga_de === 1'b1) ? 1 : 0;
        end

        if (!rst_n_v[1]) b_armed = 0;
        if (if_b.frame_start === 1'b1) begin
            if (b_armed != 0) chk("b_frame_period", 1, b_cnt, 58 * 27);
            b_armed = 1;
            b_cnt   = 1;
        end else begin
            b_cnt++;
        end
    endtask

    initial begin
        md[0] = '{128, 88, 800, 40, 4, 23, 600, 1, 1'b0, 1'b0, 1};
        md[1] = '{8, 6, 40, 4, 2, 3, 20, 2, 1'b0, 1'b1, 2};
        md[2] = '{2, 1, 4, 1, 1, 1, 3, 1, 1'b1, 1'b1, 0};
        for (int d = 0; d < NDUT; d++) begin
            pcur[d] = 0;
            dat[d]  = 8'h00;
            for (int i = 0; i < 5; i++) hist[d][i] = idle_ent(md[d]);
        end
        for (int i = 0; i < 3; i++) rq_b[i] = 8'h00;
        if_a.vga_data = 8'h00;
        if_b.vga_data = 8'h00;
        if_c.vga_data = 8'h00;
        rst_n_v = '0;
        en_v    = '1;

        repeat (5) cycle();
        chk("a_rst_hs",  0, if_a.vga_hs,      1'b1);
        chk("a_rst_vs",  0, if_a.vga_vs,      1'b1);
        chk("a_rst_de",  0, if_a.vga_de,      1'b0);
        chk("a_rst_rgb", 0, if_a.vga_rgb,     8'h00);
        chk("a_rst_fs",  0, if_a.frame_start, 1'b0);
        chk("c_rst_hs",  2, if_c.vga_hs,      1'b0);

        rst_n_v = '1;
        cycle();
        chk("a_fs_first_lo", 0, if_a.frame_start, 1'b0);
        cycle();
        chk("a_fs_first_hi", 0, if_a.frame_start, 1'b1);

        for (int i = 2; i < 31500; i++) begin
            en_v[0]    = !(i >= 500 && i < 510);
            en_v[2]    = ($urandom_range(0, 7) != 0);
            rst_n_v[2] = ($urandom_range(0, 63) != 0);
            cycle();
            if (i >= 501 && i <= 510) chk("a_de_idle", 0, if_a.vga_de, 1'b0);
            if (i == 502) chk("a_vs_idle", 0, if_a.vga_vs, 1'b1);
            if (i == 511) chk("a_fs_restart", 0, if_a.frame_start, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA controller.
- Generates H/V counters, sync pulses and the pixel-request coordinates (vga_xide/vga_yide) for any timing mode, with selectable sync polarity.
- Absorbs a configurable pixel-source fetch latency, so hs/vs/de/rgb leave aligned with the returned data.
- Includes a run-enable and frame/line strobes for the game logic. Sits between the pixel/game renderer and the VGA pins.

Parameters:
- H_SYNC, 128, hsync pulse width in clocks
- H_BP, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- V_SYNC, 4, vsync pulse width in lines
- V_BP, 23, vertical back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch
- HS_POL, 0, active level of vga_hs
- VS_POL, 0, active level of vga_vs
- RGB_W, 8, pixel width
- DATA_LAT, 1, clocks from coordinate issue to valid vga_data (legal range 0..4)
- CW, 11, counter / coordinate width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
- clk_40mhz  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run enable
- vga_data  in  RGB_W  pixel from source; valid DATA_LAT clocks after the matching vga_xide/vga_yide
- vga_xide  out  CW  requested x (0..H_ACTIVE-1), 0 when not active
- vga_yide  out  CW  requested y (0..V_ACTIVE-1), 0 when not active
- vga_req  out  1  vga_xide/vga_yide are a valid request this cycle
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  display enable, aligned with vga_rgb
- vga_rgb  out  RGB_W  pixel out; 0 whenever vga_de=0
- frame_start  out  1  one-cycle pulse on output-stage pixel (h=0,v=0)
- line_start  out  1  one-cycle pulse on output-stage h=0

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL analogous.
  - H_ACT0 = H_SYNC+H_BP; V_ACT0 = V_SYNC+V_BP.
- Counters:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments only on the cycle hcnt==H_TOTAL-1, and wraps V_TOTAL-1 -> 0 on that same cycle.
  - No off-by-one skew between H and V: vcnt changes exactly when hcnt wraps.
- Stage 0 (combinational from the counters):
  - act = (H_ACT0 <= hcnt < H_ACT0+H_ACTIVE) && (V_ACT0 <= vcnt < V_ACT0+V_ACTIVE).
  - vga_req = act. When act, vga_xide = hcnt-H_ACT0 and vga_yide = vcnt-V_ACT0; otherwise both are 0.
  - hs0 = HS_POL when hcnt < H_SYNC, else ~HS_POL. vs0 = VS_POL when vcnt < V_SYNC, else ~VS_POL.
  - fs0 = (hcnt==0 && vcnt==0); ls0 = (hcnt==0).
- Delay line: {hs0, vs0, act, fs0, ls0} pass through DATA_LAT register stages. DATA_LAT=0 is a wire.
- Output register (one stage):
  - vga_hs/vga_vs/vga_de/frame_start/line_start take the delayed values.
  - vga_rgb <= delayed_act ? vga_data : 0.
  - Total output latency relative to the counters is DATA_LAT+1 clocks. vga_data is sampled exactly DATA_LAT clocks after its coordinate is issued.
- Enable:
  - When en=0, hcnt and vcnt are held at 0 on the next edge and vga_req=0.
  - All delay stages load inactive values (sync at ~POL, act=0, strobes=0), so the outputs go idle DATA_LAT+1 clocks later.
  - When en rises, counting restarts at (0,0): the first edge with en=1 moves hcnt to 1, and frame_start fires DATA_LAT+1 clocks after en was first seen high. A new frame always begins this way; there is no resume mid-frame.
- Reset (rst_n=0 at the clock edge): hcnt=vcnt=0; all delay stages inactive; vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, vga_rgb=0, frame_start=line_start=0. Reset takes priority over en.
- Reset or en deasserted mid-line: no partial sync pulse is stretched. Outputs follow the flushed pipeline.
- Widths: all comparisons are unsigned at CW bits. The subtraction for vga_xide/vga_yide is performed only inside the active window, so it never underflows.

Decomposition:
- Package vga_timing_pkg: mode constants for 800x600@60 (40 MHz, the default above) and 640x480@60, plus a function computing H_TOTAL/V_TOTAL.
- Sub-module vga_pipe_delay: a parametrised width x depth shift register with a synchronous load-inactive (flush) input and a reset value; depth 0 is a pass-through. Used for the sync/de/strobe delay line.

Test Plan:
- Reset held 5 clocks, default parameters -> vga_hs=1, vga_vs=1, vga_de=0, vga_rgb=0, no strobes; after release, first frame_start 2 clocks after rst_n rises (DATA_LAT=1).
- Free run, default parameters -> vga_hs low for exactly 128 of every 1056 clocks; vga_vs low for exactly 4x1056 clocks per frame; frame period 1056x628 = 663168 clocks; vga_de high 800 clocks per line on 600 lines.
- Source model returns {x[3:0], y[3:0]} with DATA_LAT=2 -> on every vga_de cycle vga_rgb equals the coordinate issued 3 clocks earlier; first pixel is (0,0) at hcnt=216+3, vcnt=27; the last request of a frame is (799,599).
- en dropped at hcnt=500, vcnt=300 for 10 clocks, then raised -> outputs idle from DATA_LAT+1 clocks after the drop; frame_start DATA_LAT+1 clocks after en is first seen high; no vga_de while en=0.
- Small mode (H 2/1/4/1, V 1/1/3/1, HS_POL=1, VS_POL=1, DATA_LAT=0) -> H_TOTAL=8, V_TOTAL=6; vga_hs high at hcnt 0..1; vga_xide sequence 0,1,2,3 per active line; vga_rgb equals vga_data of the previous clock.
- vga_data driven 0xFF constantly -> vga_rgb=0 in every blanking clock, including the transitions between the last active pixel and the front porch on the wrap edges.
